// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, widths, FSM encoding and opcode legality for the ALU sequencer
package alu_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_NOT   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NAND  = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_XNOR  = 4'b0110;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_SHR   = 4'b1010;
    localparam logic [3:0] OP_SHL   = 4'b1011;
    localparam logic [3:0] OP_CLEAR = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_t;

    function automatic logic is_legal_op(input logic [3:0] opcode);
        case (opcode)
            OP_AND, OP_OR, OP_NOT, OP_XOR, OP_NAND, OP_NOR, OP_XNOR,
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_CLEAR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with wrap-bit pointers and async active-low reset
module alu_cmd_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A push is refused while full even if a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - single-issue command front-end that drives the ALU and returns its result
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W      = alu_pkg::DATA_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int ALU_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_opcode,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [3:0]        res_opcode,
    output logic              busy,
    output logic              err_illegal
);

    localparam int CMD_W = 4 + 2*DATA_W;
    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY + 1) : 1;

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_nxt;
    logic [3:0]        alu_opcode_nxt;
    logic [DATA_W-1:0] alu_a_nxt;
    logic [DATA_W-1:0] alu_b_nxt;
    logic              res_valid_nxt;
    logic [DATA_W-1:0] res_data_nxt;
    logic [3:0]        res_opcode_nxt;
    logic              err_illegal_nxt;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CMD_W-1:0]  fifo_head;
    logic [3:0]        head_opcode;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid),
        .push_data ({cmd_opcode, cmd_a, cmd_b}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_opcode = fifo_head[CMD_W-1 -: 4];
    assign head_a      = fifo_head[2*DATA_W-1 -: DATA_W];
    assign head_b      = fifo_head[DATA_W-1:0];

    assign cmd_ready = !fifo_full;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        alu_opcode_nxt  = alu_opcode;
        alu_a_nxt       = alu_a;
        alu_b_nxt       = alu_b;
        res_valid_nxt   = res_valid;
        res_data_nxt    = res_data;
        res_opcode_nxt  = res_opcode;
        err_illegal_nxt = 1'b0;
        fifo_pop        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    alu_a_nxt = head_a;
                    alu_b_nxt = head_b;
                    // Unknown opcodes are neutralised to CLEAR so the ALU never sees them.
                    if (is_legal_op(head_opcode)) begin
                        alu_opcode_nxt = head_opcode;
                    end else begin
                        alu_opcode_nxt  = OP_CLEAR;
                        err_illegal_nxt = 1'b1;
                    end
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_nxt = CNT_W'(ALU_LATENCY - 1);
                state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    res_data_nxt   = alu_result;
                    res_opcode_nxt = alu_opcode;
                    res_valid_nxt  = 1'b1;
                    state_nxt      = ST_HOLD;
                end else begin
                    wait_cnt_nxt = wait_cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            alu_opcode  <= OP_CLEAR;
            alu_a       <= '0;
            alu_b       <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_opcode  <= 4'b0000;
            err_illegal <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            alu_opcode  <= alu_opcode_nxt;
            alu_a       <= alu_a_nxt;
            alu_b       <= alu_b_nxt;
            res_valid   <= res_valid_nxt;
            res_data    <= res_data_nxt;
            res_opcode  <= res_opcode_nxt;
            err_illegal <= err_illegal_nxt;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer with a modelled ALU
module tb_alu_op_sequencer;

    localparam int DATA_W      = 16;
    localparam int FIFO_DEPTH  = 4;
    localparam int ALU_LATENCY = 2;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_opcode;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [3:0]        alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [3:0]        res_opcode;
    logic              busy;
    logic              err_illegal;

    alu_op_sequencer #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .ALU_LATENCY (ALU_LATENCY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_opcode  (res_opcode),
        .busy        (busy),
        .err_illegal (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   illegal_sent = 0;
    int   err_seen = 0;
    logic rr_rand = 1'b0;

    function automatic logic legal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                          4'h8, 4'h9, 4'hA, 4'hB, 4'hF};
    endfunction

    function automatic logic [DATA_W-1:0] alu_fn(input logic [3:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (op)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return ~a;
            4'h3:    return a ^ b;
            4'h4:    return ~(a & b);
            4'h5:    return ~(a | b);
            4'h6:    return ~(a ^ b);
            4'h8:    return a + b;
            4'h9:    return a - b;
            4'hA:    return a >> 1;
            4'hB:    return a << 1;
            default: return '0;
        endcase
    endfunction

    // Stand-in for the ALU breadboard: result settles ALU_LATENCY edges after its inputs change.
    logic [DATA_W-1:0] alu_pipe [ALU_LATENCY];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_fn(alu_opcode, alu_a, alu_b);
        for (int i = 1; i < ALU_LATENCY; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[ALU_LATENCY-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b);
        exp_t e;
        logic [3:0] sop;
        sop = legal(op) ? op : 4'hF;
        if (!legal(op)) illegal_sent++;
        e.op   = sop;
        e.data = alu_fn(sop, a, b);
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [3:0] op, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b);
        int n = 0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        while (!cmd_ready && n < 400) begin
            tick();
            n++;
        end
        check("cmd_accept_timeout", (n >= 400), 0);
        push_exp(op, a, b);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            tick();
            n++;
        end
        check(tag, (n >= 1000), 0);
    endtask

    // Result scoreboard plus protocol properties observed every cycle away from the clock edge.
    logic              prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [3:0]        prev_rop;
    logic [35:0]       prev_alu = {4'hF, 32'h0};
    int                issues = 0;
    int                delivered = 0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
            issues    = 0;
            delivered = 0;
            prev_alu  = {4'hF, 32'h0};
        end else begin
            if (prev_hold) begin
                check("hold_valid", res_valid, 1);
                check("hold_data", res_data, prev_data);
                check("hold_opcode", res_opcode, prev_rop);
            end
            if ({alu_opcode, alu_a, alu_b} != prev_alu) begin
                check("issue_after_handshake", (delivered >= issues), 1);
                issues = delivered + 1;
            end
            if (err_illegal) begin
                err_seen++;
                check("err_alu_opcode", alu_opcode, 4'hF);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", res_data, e.data);
                    check("res_opcode", res_opcode, e.op);
                end
                delivered++;
            end
            prev_hold = res_valid && !res_ready;
            prev_data = res_data;
            prev_rop  = res_opcode;
            prev_alu  = {alu_opcode, alu_a, alu_b};
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rr_rand) res_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        int   n;
        int   n_err;
        int   n_valid;
        logic stable_ok;
        logic [3:0] op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = 4'h0;
        cmd_a      = '0;
        cmd_b      = '0;
        res_ready  = 1'b1;
        repeat (3) tick();

        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_alu_opcode", alu_opcode, 4'hF);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_opcode", res_opcode, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_illegal, 0);
        rst_n = 1'b1;
        tick();

        // AND: issue timing, input stability and a single-cycle result.
        send(4'h0, 16'hC001, 16'h8001);
        n = 0;
        stable_ok = 1'b1;
        while (!res_valid && n < 30) begin
            tick();
            n++;
            if (alu_opcode !== 4'h0 || alu_a !== 16'hC001 || alu_b !== 16'h8001) stable_ok = 1'b0;
        end
        check("and_alu_stable", stable_ok, 1);
        check("and_latency", n, ALU_LATENCY + 2);
        check("and_res_data", res_data, 16'h8001);
        tick();
        check("and_valid_pulse", res_valid, 0);
        drain("and_drain");

        // ADD then SUB back to back.
        send(4'h8, 16'h0002, 16'h0003);
        send(4'h9, 16'h0002, 16'h0003);
        drain("addsub_drain");

        // Shifts.
        send(4'hA, 16'h0008, 16'h0000);
        send(4'hB, 16'h0080, 16'h0000);
        drain("shift_drain");

        // Illegal opcode is neutralised to CLEAR with a one-cycle flag.
        send(4'h7, 16'h0002, 16'h0003);
        n_err = 0;
        repeat (8) begin
            tick();
            if (err_illegal) begin
                n_err++;
                check("ill_alu_opcode", alu_opcode, 4'hF);
            end
        end
        check("ill_err_pulses", n_err, 1);
        drain("ill_drain");

        // Back-pressure: one in flight, four buffered, sixth refused.
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(4'(k), 16'($urandom), 16'($urandom));
        cmd_valid  = 1'b1;
        cmd_opcode = 4'h3;
        cmd_a      = 16'h1234;
        cmd_b      = 16'h00FF;
        repeat (6) begin
            check("bp_cmd_ready_low", cmd_ready, 0);
            tick();
        end
        check("bp_res_valid", res_valid, 1);
        check("bp_busy", busy, 1);
        res_ready = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("bp_ready_rise", n, 2);
        push_exp(4'h3, 16'h1234, 16'h00FF);
        tick();
        cmd_valid = 1'b0;
        drain("bp_drain");

        // Reset while WAITing with two commands queued.
        send(4'h8, 16'h0001, 16'h0001);
        send(4'h1, 16'h00F0, 16'h000F);
        send(4'h3, 16'h5555, 16'hFFFF);
        check("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_alu_opcode", alu_opcode, 4'hF);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_b", alu_b, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        n_valid = 0;
        repeat (30) begin
            tick();
            if (res_valid) n_valid++;
        end
        check("mid_no_result", n_valid, 0);
        check("mid_idle_busy", busy, 0);

        // Randomized traffic with random consumer stalls.
        rr_rand = 1'b1;
        for (int k = 0; k < 80; k++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if ($urandom_range(0, 4) == 0) a = 16'hFFFF;
            send(op, a, b);
            repeat ($urandom_range(0, 2)) tick();
        end
        rr_rand   = 1'b0;
        res_ready = 1'b1;
        tick();
        drain("rand_drain");
        check("err_count", err_seen, illegal_sent);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
